calc_job_issuer: RTL and testbench
==================================

Name: calc_job_issuer

Overview:
Initiator-side controller for the small calculator datapath.
- Accepts operation jobs (op, two 3-bit operands) over a valid/ready command interface.
- Drives the calculator's Go/Op/In1/In2 inputs and waits for Done, with a watchdog timeout.
- Returns the captured 3-bit result over a valid/ready response interface.
- Sits between the system sequencer and the calculator core and is the only block that drives the core.

Parameters:
TIMEOUT, 16, cycles to wait in WAIT for calc_done before declaring timeout (>=2)
CNT_W, 8, width of job_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  job request valid
cmd_ready  out  1  issuer can accept a job
cmd_op  in  2  operation: 0 XOR, 1 AND, 2 SUB, 3 ADD
cmd_a  in  3  operand A
cmd_b  in  3  operand B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  3  captured calculator result (0 on timeout)
rsp_op  out  2  echo of the job's op
rsp_timeout  out  1  job ended by watchdog, not by calc_done
calc_go  out  1  start pulse to calculator
calc_op  out  2  op to calculator
calc_in1  out  3  operand A to calculator
calc_in2  out  3  operand B to calculator
calc_done  in  1  calculator done (valid in its done state)
calc_out  in  3  calculator result, sampled only when calc_done=1
busy  out  1  state != IDLE
job_count  out  CNT_W  completed jobs (wraps at 2^CNT_W)

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including calc_go, rsp_valid and job_count.
  - Internal latches and the timer are cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP (encoding in the package).
- IDLE:
  - cmd_ready=1; all other states drive cmd_ready=0.
  - On cmd_valid=1, latch op/a/b and move to ISSUE.
- ISSUE: exactly one cycle.
  - calc_go=1; calc_op/in1/in2 driven from the latches.
  - Timer cleared; move to WAIT.
- Operand hold: calc_op/in1/in2 stay stable from ISSUE until leaving WAIT. They are 0 in IDLE and RESP.
- WAIT: calc_go=0.
  - If calc_done=1: capture calc_out into rsp_data, rsp_timeout=0, move to RESP.
  - Otherwise the timer increments. When the timer equals TIMEOUT-1 with calc_done=0: rsp_data=0, rsp_timeout=1, move to RESP.
  - calc_done asserted in the same cycle the timer expires counts as normal completion (done wins).
- RESP:
  - rsp_valid=1; rsp_data/rsp_op/rsp_timeout held stable until rsp_valid&&rsp_ready.
  - On handshake: job_count increments (wraps), move to IDLE.
- calc_done outside WAIT is ignored; no capture, no state change.
- Latency:
  - Command accepted at edge N; calc_go high during cycle N+1.
  - rsp_valid rises the cycle after calc_done is sampled.
  - With the nominal core (done 5 cycles after go), rsp_valid is high in cycle N+7.
- Throughput: at most one job outstanding. Minimum one IDLE cycle between jobs, since cmd_ready is asserted only in IDLE.
- Arithmetic: the issuer performs no arithmetic on data; the result is passed through unmodified (3-bit wrap is the core's responsibility).
- Reset mid-operation: in-flight job discarded, no response produced, calc_go/operands deasserted asynchronously.

Decomposition:
- Shared package calc_pkg:
  - op encoding constants OP_XOR=0, OP_AND=1, OP_SUB=2, OP_ADD=3
  - issuer state encoding
  - result width 3 and op width 2 constants
  - the package is reused by the calculator core and benches.
- One sub-module, calc_wdog: clearable up-counter with an expired output at TIMEOUT-1, parameterised by TIMEOUT.

Test Plan:
- a=6, b=1, ops 0..3 in sequence, with a behavioural core giving done 5 cycles after go:
  - rsp_data = 7, 0, 5, 7; rsp_timeout=0; rsp_op echoes op.
  - calc_go is high exactly 1 cycle per job; job_count ends at 4.
- a=7, b=3, ADD -> rsp_data=2 (core wrap passed through). SUB with a=1, b=3 -> rsp_data=6.
- Core never asserts done -> rsp_valid exactly TIMEOUT cycles after ISSUE, rsp_data=0, rsp_timeout=1. The next job completes normally.
- calc_done asserted on the final timer cycle with calc_out=5 -> rsp_timeout=0, rsp_data=5.
- rsp_ready held low 10 cycles in RESP:
  - rsp_* stable throughout; cmd_ready=0, cmd_valid ignored.
  - A stray calc_done pulse is ignored.
  - Then rsp_ready=1 -> IDLE, job_count+1.
- reset pulled low during WAIT:
  - calc_go/operands/busy go to 0 immediately and job_count goes to 0.
  - No rsp_valid is produced; a job after release completes correctly.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------
// calc_pkg : shared op/width/state definitions for the calculator
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam int RES_W = 3;
  localparam int OP_W  = 2;

  localparam logic [OP_W-1:0] OP_XOR = 2'd0;
  localparam logic [OP_W-1:0] OP_AND = 2'd1;
  localparam logic [OP_W-1:0] OP_SUB = 2'd2;
  localparam logic [OP_W-1:0] OP_ADD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issuer_state_e;

endpackage

`default_nettype wire

// File: rtl/calc_wdog.sv
// ---------------------------------------------------------------
// calc_wdog : clearable up-counter, expired when count hits TIMEOUT-1
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module calc_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Counter parks at the terminal value so it can never wrap back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/calc_job_issuer.sv
// ---------------------------------------------------------------
// calc_job_issuer : accepts calculator jobs, drives the core, returns results
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module calc_job_issuer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [RES_W-1:0] cmd_a,
  input  logic [RES_W-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_timeout,
  output logic             calc_go,
  output logic [OP_W-1:0]  calc_op,
  output logic [RES_W-1:0] calc_in1,
  output logic [RES_W-1:0] calc_in2,
  input  logic             calc_done,
  input  logic [RES_W-1:0] calc_out,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  issuer_state_e   state;
  logic [OP_W-1:0] job_op;
  logic            wd_clear;
  logic            wd_enable;
  logic            wd_expired;

  // Timer reads 0 in ISSUE and counts WAIT cycles from 1, so a silent core
  // yields rsp_valid exactly TIMEOUT cycles after the go pulse.
  assign wd_enable = (state == ST_ISSUE) || (state == ST_WAIT);
  assign wd_clear  = !wd_enable;

  calc_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      calc_go     <= 1'b0;
      calc_op     <= '0;
      calc_in1    <= '0;
      calc_in2    <= '0;
      job_op      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= ST_ISSUE;
            cmd_ready <= 1'b0;
            calc_go   <= 1'b1;
            calc_op   <= cmd_op;
            calc_in1  <= cmd_a;
            calc_in2  <= cmd_b;
            job_op    <= cmd_op;
          end
        end

        ST_ISSUE: begin
          calc_go <= 1'b0;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          // Done takes priority over an expiring timer in the same cycle.
          if (calc_done || wd_expired) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_op      <= job_op;
            rsp_timeout <= !calc_done;
            rsp_data    <= calc_done ? calc_out : '0;
            calc_op     <= '0;
            calc_in1    <= '0;
            calc_in2    <= '0;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_op      <= '0;
            rsp_timeout <= 1'b0;
            job_count   <= job_count + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_job_issuer.sv
// ---------------------------------------------------------------
// tb_calc_job_issuer : randomized self-checking bench with a job-level model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_calc_job_issuer;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_a;
  logic [2:0]       cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_data;
  logic [1:0]       rsp_op;
  logic             rsp_timeout;
  logic             calc_go;
  logic [1:0]       calc_op;
  logic [2:0]       calc_in1;
  logic [2:0]       calc_in2;
  logic             calc_done;
  logic [2:0]       calc_out;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  calc_job_issuer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_op      (rsp_op),
    .rsp_timeout (rsp_timeout),
    .calc_go     (calc_go),
    .calc_op     (calc_op),
    .calc_in1    (calc_in1),
    .calc_in2    (calc_in2),
    .calc_done   (calc_done),
    .calc_out    (calc_out),
    .busy        (busy),
    .job_count   (job_count)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] data;
    logic       to;
    int         delay;
    bit         go_seen;
    int         go_cyc;
  } job_t;

  job_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   exp_count = 0;
  int   since_rst = 0;
  int   core_delay = 5;
  bit   stray_pulse = 0;
  bit   core_pend = 0;
  int   core_due  = 0;
  logic [2:0] core_res;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Arithmetic the calculator core is expected to perform, 3-bit wrap.
  function automatic logic [2:0] calc_model(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    int r;
    case (op)
      2'd0: r = int'(a) ^ int'(b);
      2'd1: r = int'(a) & int'(b);
      2'd2: r = (int'(a) - int'(b) + 8) % 8;
      default: r = (int'(a) + int'(b)) % 8;
    endcase
    return 3'(r);
  endfunction

  // Behavioural calculator core: done pulses core_delay cycles after go (-1 = never).
  initial begin
    calc_done = 1'b0;
    calc_out  = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      calc_done = 1'b0;
      calc_out  = 3'($urandom);
      if (!reset) begin
        core_pend = 0;
      end else begin
        if (calc_go) begin
          core_pend = (core_delay >= 0);
          core_due  = cyc + core_delay;
          core_res  = calc_model(calc_op, calc_in1, calc_in2);
        end
        if (core_pend && cyc == core_due) begin
          calc_done = 1'b1;
          calc_out  = core_res;
          core_pend = 0;
        end
        if (stray_pulse) begin
          calc_done   = 1'b1;
          calc_out    = 3'd3;
          stray_pulse = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the job-level model.
  always @(negedge clk) begin
    job_t j;
    bit   exp_busy;
    int   rise;
    if (!reset) begin
      since_rst = 0;
    end else begin
      since_rst++;
      if (since_rst >= 2) begin
        exp_busy = (q.size() != 0);
        check("busy", 32'(busy), 32'(exp_busy));
        check("job_count", 32'(job_count), 32'(exp_count % (1 << CNT_W)));
        if (exp_busy) begin
          check("cmd_ready_busy", 32'(cmd_ready), 32'(0));
        end else if (since_rst >= 3) begin
          check("cmd_ready_idle", 32'(cmd_ready), 32'(1));
        end
        if (!exp_busy) begin
          check("go_idle", 32'(calc_go), 32'(0));
          check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
          check("ops_idle", 32'({calc_op, calc_in1, calc_in2}), 32'(0));
        end else begin
          j = q[0];
          if (!j.go_seen) begin
            check("go_start", 32'(calc_go), 32'(1));
            if (calc_go) begin
              j.go_seen = 1;
              j.go_cyc  = cyc;
              q[0] = j;
            end
          end else begin
            check("go_width", 32'(calc_go), 32'(0));
          end
          if (j.go_seen) begin
            rise = j.go_cyc + (j.to ? TIMEOUT : j.delay + 1);
            check("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= rise));
            if (!rsp_valid) begin
              check("ops_hold", 32'({calc_op, calc_in1, calc_in2}), 32'({j.op, j.a, j.b}));
            end else begin
              check("ops_resp", 32'({calc_op, calc_in1, calc_in2}), 32'(0));
              check("rsp_data", 32'(rsp_data), 32'(j.data));
              check("rsp_op", 32'(rsp_op), 32'(j.op));
              check("rsp_timeout", 32'(rsp_timeout), 32'(j.to));
              if (rsp_ready) begin
                void'(q.pop_front());
                exp_count++;
              end
            end
          end
        end
      end
    end
  end

  task automatic run_job(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input int delay, input int hold, input bit stray,
                         output logic [2:0] got_d, output logic got_to);
    job_t j;
    int   n;
    got_d  = 3'd0;
    got_to = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 32'(cmd_ready), 32'(1));
      return;
    end
    core_delay = delay;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    j.op = op; j.a = a; j.b = b; j.delay = delay;
    j.to = (delay < 0) || (delay > TIMEOUT - 1);
    j.data = j.to ? 3'd0 : calc_model(op, a, b);
    j.go_seen = 0; j.go_cyc = 0;
    q.push_back(j);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = 3'($urandom); cmd_b = 3'($urandom);
    n = 0;
    while (!rsp_valid && n < TIMEOUT + 20) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) begin
      check("rsp_valid_wait", 32'(rsp_valid), 32'(1));
      return;
    end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_a = 3'($urandom); cmd_b = 3'($urandom);
      if (stray && i == 3) stray_pulse = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    got_d  = rsp_data;
    got_to = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=%0d expected=%0d", cyc, 0);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [2:0] d;
    logic       t;
    int         dl;
    logic [2:0] exp_pin [4];
    exp_pin[0] = 3'd7; exp_pin[1] = 3'd0; exp_pin[2] = 3'd5; exp_pin[3] = 3'd7;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 3'd0; cmd_b = 3'd0; rsp_ready = 1'b0;
    #12;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_outputs", 32'({rsp_valid, calc_go, cmd_ready, job_count}), 32'(0));
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      run_job(2'(k), 3'd6, 3'd1, 5, 0, 0, d, t);
      check("pin_op_seq", 32'(d), 32'(exp_pin[k]));
      check("pin_op_seq_to", 32'(t), 32'(0));
    end
    check("pin_count4", 32'(job_count), 32'(4));

    run_job(2'd3, 3'd7, 3'd3, 5, 0, 0, d, t);
    check("pin_add_wrap", 32'(d), 32'(2));
    run_job(2'd2, 3'd1, 3'd3, 5, 0, 0, d, t);
    check("pin_sub_wrap", 32'(d), 32'(6));

    run_job(2'd1, 3'd7, 3'd5, -1, 0, 0, d, t);
    check("pin_timeout_data", 32'(d), 32'(0));
    check("pin_timeout_flag", 32'(t), 32'(1));
    run_job(2'd0, 3'd5, 3'd3, 2, 0, 0, d, t);
    check("pin_after_timeout", 32'(d), 32'(6));

    run_job(2'd3, 3'd2, 3'd3, TIMEOUT - 1, 0, 0, d, t);
    check("pin_done_wins", 32'(d), 32'(5));
    check("pin_done_wins_to", 32'(t), 32'(0));

    run_job(2'd2, 3'd4, 3'd6, 3, 10, 1, d, t);
    check("pin_hold_data", 32'(d), 32'(6));
    check("pin_hold_count", 32'(job_count), 32'(10));

    // Reset pulled in the middle of WAIT.
    while (!cmd_ready) begin @(posedge clk); #1; end
    core_delay = -1;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 3'd5; cmd_b = 3'd6;
    @(posedge clk);
    begin
      job_t j;
      j.op = 2'd3; j.a = 3'd5; j.b = 3'd6; j.delay = -1; j.to = 1; j.data = 3'd0;
      j.go_seen = 0; j.go_cyc = 0;
      q.push_back(j);
    end
    #1 cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("rst_go", 32'(calc_go), 32'(0));
    check("rst_ops", 32'({calc_op, calc_in1, calc_in2}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_count", 32'(job_count), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    q.delete();
    exp_count = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    run_job(2'd1, 3'd6, 3'd3, 5, 1, 0, d, t);
    check("pin_after_reset", 32'(d), 32'(2));
    check("pin_after_reset_count", 32'(job_count), 32'(1));

    for (int k = 0; k < 25; k++) begin
      dl = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 2));
      run_job(2'($urandom), 3'($urandom), 3'($urandom), dl, int'($urandom_range(0, 5)),
              1'($urandom), d, t);
    end
    repeat (3) @(posedge clk);
    check("final_queue_empty", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
